// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - ifetch shared widths, states and buffer depth (IFETCH_BUF2_EN selects DEPTH=2)
`ifndef INSTRSIZE
`define INSTRSIZE 32
`endif

package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

`ifdef IFETCH_BUF2_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0]             pc;
        logic [`INSTRSIZE-1:0]   instr;
    } buf_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory, redirect and decode handshake bundle for ifetch
interface ifetch_if;
    import ifetch_pkg::*;

    logic                  imem_req;
    logic [31:0]           imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  ins_valid;
    logic [`INSTRSIZE-1:0] insData;
    logic [31:0]           ins_pc;
    logic                  ins_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output ins_valid, insData, ins_pc,
        input  ins_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  ins_valid, insData, ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - {pc, instr} instruction buffer; IFETCH_BUF2_EN builds a 2-entry FIFO, else one holding register
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  buf_entry_t push_data,
    output buf_entry_t head,
    output logic [1:0] count
);

    logic push_ok;
    logic pop_ok;

    // Issue reserves the slot, so a full push is dropped only as a safety net.
    assign push_ok = push && (count != 2'(DEPTH));
    assign pop_ok  = pop && (count != 2'd0);

`ifdef IFETCH_BUF2_EN
    buf_entry_t mem0, mem1;
    logic       wp, rp;
    logic [1:0] cnt;

    assign count = cnt;
    assign head  = rp ? mem1 : mem0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0 <= '0;
            mem1 <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            cnt  <= 2'd0;
        end else if (flush) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wp) mem1 <= push_data;
                else    mem0 <= push_data;
                wp <= !wp;
            end
            if (pop_ok) rp <= !rp;
            cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end
`else
    buf_entry_t entry;
    logic       full;

    assign count = {1'b0, full};
    assign head  = entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            full  <= 1'b0;
        end else if (flush) begin
            full  <= 1'b0;
        end else if (push_ok) begin
            entry <= push_data;
            full  <= 1'b1;
        end else if (pop_ok) begin
            full  <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - single-outstanding instruction fetch FSM with redirect/drop handling (IFETCH_BUF2_EN: 2-entry buffer)
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);

    state_e      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [1:0]  count;
    logic        push, pop, flush, req;
    buf_entry_t  head;

    // Gated by rst_n so the request drops the moment reset asserts.
    assign req = rst_n && (state == ST_IDLE) && (count < 2'(BUF_DEPTH))
                 && !bus.redirect_valid;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.ins_valid = (count != 2'd0);
    assign bus.insData   = head.instr;
    assign bus.ins_pc    = head.pc;

    assign flush = bus.redirect_valid;
    assign pop   = bus.ins_valid && bus.ins_ready && !bus.redirect_valid;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        push         = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_nxt = word_align(bus.redirect_pc);
            if (state == ST_WAIT)
                state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && bus.imem_gnt) begin
                        req_pc_nxt   = fetch_pc;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rvalid) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'd0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    ifetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ('{pc: req_pc, instr: bus.imem_rdata}),
        .head      (head),
        .count     (count)
    );

endmodule
